// File: rtl/reg_file_if.sv
// ---------------------------------------------------------------------------
// reg_file_if -- bus bundle for the register file.
//
// Signals:
//   wrEn  write enable                     (master -> slave)
//   rd    write register index             (master -> slave)
//   dIn   write data                       (master -> slave)
//   rs1   read port 1 register index       (master -> slave)
//   rs2   read port 2 register index       (master -> slave)
//   r1    read port 1 data                 (slave -> master)
//   r2    read port 2 data                 (slave -> master)
//
// Modports:
//   master  drives the write/read controls and receives read data
//   slave   the register file itself
// ---------------------------------------------------------------------------
interface reg_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wrEn;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] dIn;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [DATA_W-1:0] r1;
    logic [DATA_W-1:0] r2;

    modport master (
        output wrEn, rd, dIn, rs1, rs2,
        input  r1, r2
    );

    modport slave (
        input  wrEn, rd, dIn, rs1, rs2,
        output r1, r2
    );
endinterface

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file -- 2**ADDR_W x DATA_W register file, one write port, two
// independent combinational read ports. Register 0 is hardwired to zero.
//
// Ports:
//   clk   single clock, all state changes on its rising edge
//   rst   synchronous active-high reset, clears every register
//   bus   reg_file_if.slave: wrEn/rd/dIn write port, rs1/rs2 read
//         indices, r1/r2 read data
//
// Reads are asynchronous from the flop outputs, so a write to a selected
// register shows up on r1/r2 only after the clock edge (no bypass).
// ---------------------------------------------------------------------------
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic       clk,
    input  logic       rst,
    reg_file_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    // Flattened view of every register, index 0 tied to zero.
    logic [DATA_W-1:0] rf_view [DEPTH];

    // Register 0 has no storage at all, so it reads 0 even before the
    // first reset and writes to it vanish.
    assign rf_view[0] = '0;

    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_reg
        logic [DATA_W-1:0] reg_q;
        logic [DATA_W-1:0] reg_d;

        always_comb begin
            reg_d = reg_q;
            if (bus.wrEn && (bus.rd == ADDR_W'(gi))) begin
                reg_d = bus.dIn;
            end
        end

        // Reset wins over a simultaneous write.
        always_ff @(posedge clk) begin
            if (rst) begin
                reg_q <= '0;
            end else begin
                reg_q <= reg_d;
            end
        end

        assign rf_view[gi] = reg_q;
    end

    assign bus.r1 = rf_view[bus.rs1];
    assign bus.r2 = rf_view[bus.rs2];

endmodule

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file -- directed self-checking bench for reg_file.
// ---------------------------------------------------------------------------
module tb_reg_file;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    reg_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge and settle one time unit.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        vectors++;
        assert (obs === exp) begin
            $display("[%0d] %s ok: observed %h expected %h", vectors, tag, obs, exp);
        end else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [DATA_W-1:0] exp1;
        logic [DATA_W-1:0] exp2;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        bus.wrEn    = 1'b0;
        bus.rd      = '0;
        bus.dIn     = '0;
        bus.rs1     = '0;
        bus.rs2     = '0;
        #1;

        // Register 0 reads zero even before any reset.
        check("pre_reset_r1_idx0", bus.r1, 32'h0);

        // Reset for one edge, then read two arbitrary registers.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.rs1 = 5'd8;
        bus.rs2 = 5'd23;
        #1;
        check("reset_r1_idx8", bus.r1, 32'h0);
        check("reset_r2_idx23", bus.r2, 32'h0);

        // Write to register 0 is ignored.
        bus.wrEn = 1'b1;
        bus.rd   = 5'd0;
        bus.dIn  = 32'hFAFAFA00;
        tick();
        bus.wrEn = 1'b0;
        bus.rs1  = 5'd0;
        #1;
        check("write_idx0_ignored", bus.r1, 32'h0);

        // Fill registers 1..31 with FAFAFA00+i.
        bus.wrEn = 1'b1;
        for (int i = 1; i < 32; i++) begin
            bus.rd  = 5'(i);
            bus.dIn = 32'hFAFAFA00 + 32'(i);
            tick();
        end
        bus.wrEn = 1'b0;

        // Read pairs (1,2),(3,4)...(31,0).
        for (int i = 1; i < 32; i += 2) begin
            bus.rs1 = 5'(i);
            bus.rs2 = 5'((i + 1) % 32);
            exp1 = 32'hFAFAFA00 + 32'(i);
            exp2 = (i == 31) ? 32'h0 : 32'hFAFAFA00 + 32'(i + 1);
            #1;
            check($sformatf("pair_r1_idx%0d", i), bus.r1, exp1);
            check($sformatf("pair_r2_idx%0d", (i + 1) % 32), bus.r2, exp2);
        end

        // Same index on both ports.
        bus.rs1 = 5'd17;
        bus.rs2 = 5'd17;
        #1;
        check("same_idx_r1", bus.r1, 32'hFAFAFA11);
        check("same_idx_r2", bus.r2, 32'hFAFAFA11);

        // No bypass: old value before the edge, new value after it.
        bus.rs1  = 5'd5;
        bus.rd   = 5'd5;
        bus.dIn  = 32'h12345678;
        bus.wrEn = 1'b1;
        #1;
        check("nobypass_before_edge", bus.r1, 32'hFAFAFA05);
        tick();
        check("nobypass_after_edge", bus.r1, 32'h12345678);
        bus.wrEn = 1'b0;

        // wrEn=0 over several edges leaves register 7 alone.
        bus.rd  = 5'd7;
        bus.dIn = 32'hDEADBEEF;
        tick();
        tick();
        tick();
        bus.rs1 = 5'd7;
        #1;
        check("wren0_hold_idx7", bus.r1, 32'hFAFAFA07);

        // Short rst pulse between edges is ignored.
        #1;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        tick();
        bus.rs1 = 5'd9;
        bus.rs2 = 5'd5;
        #1;
        check("glitch_rst_idx9", bus.r1, 32'hFAFAFA09);
        check("glitch_rst_idx5", bus.r2, 32'h12345678);

        // Reset beats a simultaneous write to register 3.
        bus.rs1  = 5'd3;
        #1;
        check("pre_rst_idx3", bus.r1, 32'hFAFAFA03);
        rst      = 1'b1;
        bus.wrEn = 1'b1;
        bus.rd   = 5'd3;
        bus.dIn  = 32'h1;
        tick();
        rst      = 1'b0;
        bus.wrEn = 1'b0;
        #1;
        check("rst_over_write_idx3", bus.r1, 32'h0);
        for (int i = 0; i < 32; i += 2) begin
            bus.rs1 = 5'(i);
            bus.rs2 = 5'(i + 1);
            #1;
            check($sformatf("post_rst_r1_idx%0d", i), bus.r1, 32'h0);
            check($sformatf("post_rst_r2_idx%0d", i + 1), bus.r2, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register and data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register index width; depth is 2**ADDR_W (32 registers).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; reset is synchronous and active-high.
REQ-005 SHALL have port wrEn, input, 1, write enable.
REQ-006 SHALL have port rd, input, ADDR_W, write register index.
REQ-007 SHALL have port dIn, input, DATA_W, write data.
REQ-008 SHALL have port rs1, input, ADDR_W, read port 1 register index.
REQ-009 SHALL have port rs2, input, ADDR_W, read port 2 register index.
REQ-010 SHALL have port r1, output, DATA_W, read port 1 data.
REQ-011 SHALL have port r2, output, DATA_W, read port 2 data.

Function
REQ-012 SHALL hold 2**ADDR_W registers of DATA_W bits each, indexed 0..31.
REQ-013 SHALL hardwire register 0 to zero; a write to index 0 is ignored and any read of index 0 returns 0.
REQ-014 SHALL write dIn into register rd on a rising clk edge when wrEn=1, rst=0 and rd!=0.
REQ-015 SHALL leave all registers unchanged on a rising edge when wrEn=0.
REQ-016 SHALL drive r1 combinationally (zero-cycle latency) from the register selected by rs1.
REQ-017 SHALL drive r2 combinationally (zero-cycle latency) from the register selected by rs2.
REQ-018 SHALL make both read ports fully independent, so rs1=rs2 returns the same value on both outputs.
REQ-019 SHALL provide no write-to-read bypass: when rs1 or rs2 equals rd with wrEn=1, the old value is output before the edge and the new value after it.
REQ-020 SHALL update r1 and r2 immediately after a clock edge that changes a selected register.
REQ-021 SHALL update r1 and r2 immediately when rs1 or rs2 changes, with no clock required.
REQ-022 SHALL contain no X-propagating state after the first reset.

Reset
REQ-023 SHALL clear all registers to 0 on a rising clk edge when rst=1.
REQ-024 SHALL give reset priority over a simultaneous write, discarding that write.
REQ-025 SHALL drive r1=0 and r2=0 after the reset edge for every rs1/rs2 value.
REQ-026 SHALL ignore an rst pulse that does not span a rising clk edge; contents are retained.
REQ-027 SHALL have reset register contents undefined until the first reset edge, except register 0, which always reads 0.

Verification
REQ-028 SHALL be verified by: rst=1 for one edge, then rs1=8, rs2=23 -> r1=0, r2=0.
REQ-029 SHALL be verified by: wrEn=1, rd=0, dIn=32'hFAFAFA00, then rs1=0 -> r1=0.
REQ-030 SHALL be verified by: write rd=i, dIn=32'hFAFAFA00+i for i=1..31, then wrEn=0 and read pairs (1,2),(3,4)...(31,0) -> e.g. r1=32'hFAFAFA01, r2=32'hFAFAFA02; (31,0) -> r1=32'hFAFAFA1F, r2=0.
REQ-031 SHALL be verified by: rs1=rd=5, old value 32'hFAFAFA05, write 32'h12345678 -> r1=32'hFAFAFA05 before the edge and 32'h12345678 after it.
REQ-032 SHALL be verified by: wrEn=0, rd=7, dIn=32'hDEADBEEF over several edges -> register 7 is unchanged.
REQ-033 SHALL be verified by: rst=1 together with wrEn=1, rd=3, dIn=32'h1 on one edge -> all registers are 0, including register 3.
REQ-034 SHALL be verified by: a 1-time-unit rst pulse between edges -> contents are unchanged.
